// File: rtl/mem_lab_pkg.sv
// Shared definitions for the memory-sweep lab controller.
//   state_e   : controller state encoding
//   SEG_ZERO  : active-low glyph for hex 0 (also the display after reset)
//   HEX_GLYPH : active-low {g,f,e,d,c,b,a} glyphs for hex 0..F
package mem_lab_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_WRITE,
    ST_SHOW,
    ST_NEXT,
    ST_DONE
  } state_e;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // b and d are the lowercase glyphs so they stay distinct from 8 and 0.
  localparam logic [6:0] HEX_GLYPH [16] = '{
    SEG_ZERO,     // 0
    7'b1111001,   // 1
    7'b0100100,   // 2
    7'b0110000,   // 3
    7'b0011001,   // 4
    7'b0010010,   // 5
    7'b0000010,   // 6
    7'b1111000,   // 7
    7'b0000000,   // 8
    7'b0010000,   // 9
    7'b0001000,   // A
    7'b0000011,   // b
    7'b1000110,   // C
    7'b0100001,   // d
    7'b0000110,   // E
    7'b0001110    // F
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit decoder.
//   nibble : 4-bit value to display
//   seg_n  : active-low segments {g,f,e,d,c,b,a}
module hex_to_7seg
  import mem_lab_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_GLYPH[nibble];

endmodule

// File: rtl/mem_sweep_fsm.sv
// Memory sweep controller: walks START_ADDR..END_ADDR of a synchronous
// single-port RAM (1-cycle read latency), optionally writes back each word
// plus INCR, and shows the current word in hex on NUM_DIGITS displays.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : begin a sweep from IDLE/DONE (ignored while busy)
//   mode, wrap      : 1 = read-increment-write / loop forever; latched on start
//   pause           : stalls the per-word hold counter while in SHOW
//   mem_addr/we/wdata, mem_rdata : RAM interface
//   busy, done      : status
//   cur_addr        : address of the word currently displayed
//   seg             : NUM_DIGITS active-low 7-seg digits, digit 0 in bits [6:0]
module mem_sweep_fsm
  import mem_lab_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_DIGITS  = 4,
  parameter int START_ADDR  = 0,
  parameter int END_ADDR    = 15,
  parameter int HOLD_CYCLES = 25000000,
  parameter int INCR        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    wrap,
  input  logic                    pause,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   cur_addr,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] A_START  = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_END    = ADDR_WIDTH'(END_ADDR);
  localparam logic [DATA_WIDTH-1:0] D_INCR   = DATA_WIDTH'(INCR);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   disp_q, disp_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mode_q, mode_d;
  logic                    wrap_q, wrap_d;
  logic [DATA_WIDTH-1:0]   wr_val;

  assign wr_val = data_q + D_INCR;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= A_START;
      cur_addr_q <= A_START;
      data_q     <= '0;
      disp_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cur_addr_q <= cur_addr_d;
      data_q     <= data_d;
      disp_q     <= disp_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      wrap_q     <= wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cur_addr_d = cur_addr_q;
    data_d     = data_q;
    disp_d     = disp_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    wrap_d     = wrap_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d  = mode;
          wrap_d  = wrap;
          addr_d  = A_START;
          state_d = ST_READ;
        end
      end
      // Address is presented here; the RAM returns the word next cycle.
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: begin
        data_d = mem_rdata;
        if (mode_q) begin
          state_d = ST_WRITE;
        end else begin
          disp_d     = mem_rdata;
          cur_addr_d = addr_q;
          state_d    = ST_SHOW;
        end
      end
      ST_WRITE: begin
        disp_d     = wr_val;
        cur_addr_d = addr_q;
        state_d    = ST_SHOW;
      end
      ST_SHOW: begin
        if (!pause) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_NEXT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_NEXT: begin
        if (addr_q == A_END) begin
          if (wrap_q) begin
            addr_d  = A_START;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops mem_we at once.
  assign mem_addr  = addr_q;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_wdata = mem_we ? wr_val : '0;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign cur_addr  = cur_addr_q;

  // Digits past the top of the data word show a zero nibble.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [3:0] nib;
    if (4*i + 4 <= DATA_WIDTH) begin : g_full
      assign nib = disp_q[4*i+3:4*i];
    end else if (4*i < DATA_WIDTH) begin : g_part
      assign nib = 4'(disp_q[DATA_WIDTH-1:4*i]);
    end else begin : g_none
      assign nib = 4'd0;
    end
    hex_to_7seg u_hex (
      .nibble (nib),
      .seg_n  (seg[7*i+6:7*i])
    );
  end

endmodule

// File: doc/mem_sweep_fsm.md
Name: mem_sweep_fsm

Overview:
- Parametrised memory-access controller; next generation of the lab's fixed FSM wrapper.
- Sweeps an address window of an external synchronous single-port RAM with one-cycle read latency.
- Optionally read-modify-writes each word by a programmable increment; shows the current word in hex on NUM_DIGITS seven-segment displays.
- Sits between the board top level (switch/key inputs, HEX outputs) and the lab RAM block.

Parameters:
- DATA_WIDTH, 16: RAM word width in bits, 1..32.
- ADDR_WIDTH, 8: RAM address width.
- NUM_DIGITS, 4: number of seven-segment digits driven, 1..8.
- START_ADDR, 0: first address of the sweep window.
- END_ADDR, 15: last address of the window; must be >= START_ADDR.
- HOLD_CYCLES, 25000000: cycles each word is displayed; must be >= 1.
- INCR, 1: value added in RMW mode, modulo 2^DATA_WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE; ignored while busy.
- mode  in  1  0 = read/display only, 1 = read-increment-write; sampled on the accepted start.
- wrap  in  1  1 = loop continuously, 0 = stop after END_ADDR; sampled on the accepted start.
- pause  in  1  freezes the hold counter while high.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in the DONE state.
- cur_addr  out  ADDR_WIDTH  address currently displayed.
- seg  out  7*NUM_DIGITS  active-low segments {g,f,e,d,c,b,a}; digit i occupies bits [7i+6:7i]; digit 0 is least significant.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; mem_addr=START_ADDR; mem_we=0; mem_wdata=0; busy=0; done=0; cur_addr=START_ADDR.
  - Display value = 0, so every digit shows 7'b1000000.
  - Reset mid-write deasserts mem_we immediately.
- States: IDLE, READ, CAPT, WRITE, SHOW, NEXT, DONE.
- IDLE/DONE + start: latch mode and wrap, addr=START_ADDR, go to READ.
- READ (1 cycle): mem_addr=addr, mem_we=0.
- CAPT (1 cycle): data_q <= mem_rdata.
- WRITE (mode 1 only, 1 cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=data_q+INCR, truncated to DATA_WIDTH.
  - Display value and cur_addr register the written value and addr.
- Mode 0: CAPT goes directly to SHOW. The display and cur_addr update at the end of CAPT with mem_rdata.
- SHOW: hold counter counts HOLD_CYCLES cycles, then NEXT.
  - pause=1 stalls the counter and the state; pause is ignored in all other states.
- NEXT (1 cycle):
  - If addr==END_ADDR: wrap=1 sets addr=START_ADDR and goes to READ; wrap=0 goes to DONE.
  - Otherwise addr+1 and READ.
- Cycles per word: mode 1 = 4+HOLD_CYCLES; mode 0 = 3+HOLD_CYCLES.
- DONE: the display keeps the last word; done=1 until the next start.
- mem_we is high only in WRITE; exactly one write per word per pass.
- Display:
  - Digit i shows nibble [4i+3:4i] of the display value.
  - Bits beyond DATA_WIDTH read as 0.
  - Hex A–F use standard 7-seg glyphs (b and d lowercase).
- start and pause are synchronous to clk; the top level debounces and synchronises them.

Decomposition:
- Shared package mem_lab_pkg:
  - State enum.
  - SEG_ZERO constant (7'b1000000).
  - The 16-entry hex glyph table.
- One sub-module hex_to_7seg: 4-bit in, 7-bit active-low out, purely combinational, instantiated NUM_DIGITS times by generate.

Test Plan:
Common setup: DATA_WIDTH=16, ADDR_WIDTH=4, START_ADDR=2, END_ADDR=4, HOLD_CYCLES=3, INCR=1, NUM_DIGITS=4. Behavioural RAM preloaded with mem[2]=16'h00FF, mem[3]=16'hFFFF, mem[4]=16'h1234.
- Reset: rst high for 2 cycles, then low -> busy=0, done=0, mem_we=0, seg={4{7'b1000000}}, cur_addr=2.
- RMW single pass: start with mode=1, wrap=0 -> exactly 3 writes, to addresses 2/3/4 with values 0100/0000/1235.
  - The FFFF word wraps to 0000.
  - done rises 21 cycles after start.
  - Final seg shows "1235".
- Read-only: start with mode=0 -> no mem_we pulses; the displayed sequence is 00FF, FFFF, 1234; 18 cycles to done.
- Wrap and pause:
  - mode=1, wrap=1 -> after address 4 the sweep returns to 2 and writes 0101.
  - pause held 10 cycles during SHOW -> the word is held for 13 cycles total.
- Start while busy: a second start pulse mid-sweep is ignored; the sequence is unchanged.
- Reset mid-write: assert rst during WRITE at address 3 -> mem_we drops the same cycle, state=IDLE, seg shows "0000", mem[3] is unchanged.
